rrf_alloc_ctrl: RTL and testbench
=================================

// Module: rrf_alloc_ctrl
// PURPOSE
// - Rename-register (RRF) allocation controller for the dual-issue register file.
// - Owns the RRF free list as a circular FIFO of tags. Grants up to 2 destination tags per cycle to decode slots A/B and drives the register file's map_en/rrError.
// - Reclaims up to 2 tags per cycle from retire. Restores the full list on pipeline flush.
// PARAMETERS
// - RRF_DEPTH  16  number of rename registers; power of 2, >=4
// - TAG_W      4   tag width, = log2(RRF_DEPTH)
// PORTS
// - clk          in   1      system clock, all state on posedge
// - rst_n        in   1      reset, synchronous, active-low
// - map_req_A    in   1      decode slot A has a GPR-writing instr needing a tag
// - map_req_B    in   1      decode slot B (younger than A) needs a tag
// - alloc_gnt_A  out  1      tag granted to A this cycle (-> register file map_en_A)
// - alloc_gnt_B  out  1      tag granted to B this cycle (-> map_en_B)
// - alloc_tag_A  out  TAG_W  tag for A; valid only when alloc_gnt_A=1
// - alloc_tag_B  out  TAG_W  tag for B; valid only when alloc_gnt_B=1
// - rrError_A    out  1      map_req_A & ~alloc_gnt_A (decode stalls)
// - rrError_B    out  1      map_req_B & ~alloc_gnt_B
// - free_en_A    in   1      retire releases free_tag_A
// - free_tag_A   in   TAG_W  released tag, port A
// - free_en_B    in   1      retire releases free_tag_B
// - free_tag_B   in   TAG_W  released tag, port B
// - flush        in   1      squash: all tags return to free list
// - free_count   out  TAG_W+1  tags currently free, 0..RRF_DEPTH
// - err_overflow out  1      sticky: a free was pushed into a full list
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - head=0, tail=0, count=RRF_DEPTH, fifo[i]=i, err_overflow=0.
//   - While rst_n=0: alloc_gnt_*=0, rrError_*=0.
// - Allocation is combinational from registered state; pointers update at the next edge.
//   - alloc_tag_A = fifo[head].
//   - alloc_tag_B = fifo[head + (alloc_gnt_A ? 1 : 0)], mod RRF_DEPTH.
//   - alloc_gnt_A = map_req_A & (count >= 1).
//   - alloc_gnt_B = map_req_B & (~map_req_A | alloc_gnt_A) & (count >= 1 + alloc_gnt_A).
//   - B is never granted when A is refused (in-order rename).
//   - n_alloc = gnt_A + gnt_B; head += n_alloc.
// - Free:
//   - Pushes at tail in order: A's tag first, then B's.
//   - n_free = free_en_A + free_en_B; tail += n_free.
//   - A freed tag is first grantable the cycle after its free (no same-cycle bypass).
// - Simultaneous alloc and free: count_next = count - n_alloc + n_free. Grant decisions use the pre-edge count only.
// - Pointer wrap: all pointer arithmetic is modulo RRF_DEPTH (natural TAG_W-bit overflow).
// - Overflow: if count + n_free - n_alloc > RRF_DEPTH, set err_overflow (sticky until reset) and saturate count at RRF_DEPTH. Excess pushes are dropped.
// - Flush (highest priority after reset):
//   - Next state equals the reset state, except err_overflow is held.
//   - Same-cycle map_req_* and free_en_* are ignored; alloc_gnt_*=0.
// - Double-free and freeing never-allocated tags are not detected; guarding against them is retire logic's responsibility.
// - free_count = count (registered).
// STRUCTURE
// - Shared package rrf_pkg:
//   - RRF_DEPTH, TAG_W
//   - typedef rrf_tag_t [TAG_W-1:0]
//   - typedef rrf_cnt_t [TAG_W:0]
// - One sub-module: rrf_freelist_fifo. Circular 2-write/2-read-port tag store with head/tail/count. Reset/flush init to identity order.
// - Top holds the grant logic and the error flag.
// TESTING
// - Reset, then map_req_A=B=1 -> gnt_A=gnt_B=1, tags 0,1; next cycle free_count=14.
// - Allocate until free_count=1, then A=B=1 -> gnt_A=1, gnt_B=0, rrError_B=1; free_count=0 next cycle.
// - free_count=0, free_en_A=1 (tag 5) with map_req_A=1 -> rrError_A=1; next cycle gnt_A=1, tag_A=5.
// - Free_count=2, A=B=1 alloc and 2 frees in the same cycle -> free_count stays 2; tags wrap after index 15 -> 0.
// - Mid-run flush=1 with map_req_A=1 -> gnt_A=0; next cycle free_count=16, tag_A=0.
// - Full list (16), free_en_A=1 -> err_overflow=1 and stays 1 through flush; cleared only by rst_n=0.

Source files
------------

// File: rtl/rrf_pkg.sv
// Shared sizing and types for the rename-register free-list controller.
package rrf_pkg;
    localparam int RRF_DEPTH = 16;
    localparam int TAG_W     = $clog2(RRF_DEPTH);

    typedef logic [TAG_W-1:0] rrf_tag_t;
    typedef logic [TAG_W:0]   rrf_cnt_t;

    function automatic logic [1:0] sum2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Decode/retire/flush handshake bundle between the pipeline and the RRF allocator.
interface rrf_alloc_ctrl_if;
    import rrf_pkg::*;

    logic     map_req_A, map_req_B;
    logic     alloc_gnt_A, alloc_gnt_B;
    rrf_tag_t alloc_tag_A, alloc_tag_B;
    logic     rrError_A, rrError_B;
    logic     free_en_A, free_en_B;
    rrf_tag_t free_tag_A, free_tag_B;
    logic     flush;
    rrf_cnt_t free_count;
    logic     err_overflow;

    modport master (
        output map_req_A, map_req_B, free_en_A, free_tag_A, free_en_B, free_tag_B, flush,
        input  alloc_gnt_A, alloc_gnt_B, alloc_tag_A, alloc_tag_B, rrError_A, rrError_B,
               free_count, err_overflow
    );

    modport slave (
        input  map_req_A, map_req_B, free_en_A, free_tag_A, free_en_B, free_tag_B, flush,
        output alloc_gnt_A, alloc_gnt_B, alloc_tag_A, alloc_tag_B, rrError_A, rrError_B,
               free_count, err_overflow
    );
endinterface

// File: rtl/rrf_freelist_fifo.sv
// Circular tag store, 2 pops and 2 pushes per cycle; reset/flush reload identity order.
module rrf_freelist_fifo
    import rrf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [1:0] n_pop,
    input  logic       push_a,
    input  logic       push_b,
    input  rrf_tag_t   wr_tag_a,
    input  rrf_tag_t   wr_tag_b,
    output rrf_tag_t   rd_tag0,
    output rrf_tag_t   rd_tag1,
    output rrf_cnt_t   count
);
    rrf_tag_t mem [RRF_DEPTH];
    rrf_tag_t head, tail;

    assign rd_tag0 = mem[head];
    assign rd_tag1 = mem[head + rrf_tag_t'(1)];

    // Caller guarantees pushes never exceed free space, so count cannot pass RRF_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= rrf_cnt_t'(RRF_DEPTH);
            for (int i = 0; i < RRF_DEPTH; i++) mem[i] <= rrf_tag_t'(i);
        end else begin
            if (push_a) mem[tail] <= wr_tag_a;
            if (push_b) mem[push_a ? tail + rrf_tag_t'(1) : tail] <= wr_tag_b;
            head  <= head + rrf_tag_t'(n_pop);
            tail  <= tail + rrf_tag_t'(sum2(push_a, push_b));
            count <= count - rrf_cnt_t'(n_pop) + rrf_cnt_t'(sum2(push_a, push_b));
        end
    end
endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF allocation controller: in-order dual grant from the free list, retire reclaim, sticky overflow flag.
module rrf_alloc_ctrl
    import rrf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    rrf_alloc_ctrl_if.slave   bus
);
    localparam int SPW = TAG_W + 2;

    rrf_cnt_t       count;
    rrf_tag_t       tag0, tag1;
    logic           active, gnt_a, gnt_b, push_a, push_b, drop;
    logic [1:0]     n_alloc;
    logic [SPW-1:0] space;
    logic           err_q;

    assign active = rst_n & ~bus.flush;

    always_comb begin
        gnt_a   = active & bus.map_req_A & (count >= rrf_cnt_t'(1));
        gnt_b   = active & bus.map_req_B & (~bus.map_req_A | gnt_a)
                & (count >= (gnt_a ? rrf_cnt_t'(2) : rrf_cnt_t'(1)));
        n_alloc = sum2(gnt_a, gnt_b);
        // Slots popped this edge are reusable by same-edge pushes.
        space   = SPW'(RRF_DEPTH) - SPW'(count) + SPW'(n_alloc);
        push_a  = active & bus.free_en_A & (space >= SPW'(1));
        push_b  = active & bus.free_en_B & (space >= (push_a ? SPW'(2) : SPW'(1)));
        drop    = active & ((bus.free_en_A & ~push_a) | (bus.free_en_B & ~push_b));
    end

    rrf_freelist_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .n_pop    (n_alloc),
        .push_a   (push_a),
        .push_b   (push_b),
        .wr_tag_a (bus.free_tag_A),
        .wr_tag_b (bus.free_tag_B),
        .rd_tag0  (tag0),
        .rd_tag1  (tag1),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)    err_q <= 1'b0;
        else if (drop) err_q <= 1'b1;
    end

    assign bus.alloc_gnt_A  = gnt_a;
    assign bus.alloc_gnt_B  = gnt_b;
    assign bus.alloc_tag_A  = tag0;
    assign bus.alloc_tag_B  = gnt_a ? tag1 : tag0;
    assign bus.rrError_A    = active & bus.map_req_A & ~gnt_a;
    assign bus.rrError_B    = active & bus.map_req_B & ~gnt_b;
    assign bus.free_count   = count;
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Scoreboard bench for rrf_alloc_ctrl: queue-based free-list model, directed corners then random traffic.
module tb_rrf_alloc_ctrl;
    import rrf_pkg::*;

    typedef struct {
        int ga, gb, ta, tb, ea, eb, cnt, err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    rrf_alloc_ctrl_if bus();

    rrf_alloc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   fm[$];
    int   inflight[$];
    int   m_err;

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void mreset();
        fm.delete();
        for (int i = 0; i < RRF_DEPTH; i++) fm.push_back(i);
        inflight.delete();
    endfunction

    function automatic void drop_tag(int t);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i] == t) begin inflight.delete(i); return; end
    endfunction

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge.
    task automatic step(bit ra, bit rb, bit fa, int ta, bit fb, int tb, bit fl, bit rs);
        exp_t e;
        @(posedge clk); #1;
        rst_n          = ~rs;
        bus.map_req_A  = ra;
        bus.map_req_B  = rb;
        bus.free_en_A  = fa;
        bus.free_tag_A = rrf_tag_t'(ta);
        bus.free_en_B  = fb;
        bus.free_tag_B = rrf_tag_t'(tb);
        bus.flush      = fl;
        e.cnt = fm.size();
        e.err = m_err;
        e.ta  = 0;
        e.tb  = 0;
        if (rs || fl) begin
            e.ga = 0; e.gb = 0; e.ea = 0; e.eb = 0;
        end else begin
            e.ga = (ra && fm.size() >= 1) ? 1 : 0;
            e.gb = (rb && (!ra || e.ga == 1) && fm.size() >= 1 + e.ga) ? 1 : 0;
            if (e.ga == 1) e.ta = fm[0];
            if (e.gb == 1) e.tb = (e.ga == 1) ? fm[1] : fm[0];
            e.ea = (ra && e.ga == 0) ? 1 : 0;
            e.eb = (rb && e.gb == 0) ? 1 : 0;
        end
        exp_q.push_back(e);
        if (rs) begin
            mreset();
            m_err = 0;
        end else if (fl) begin
            mreset();
        end else begin
            if (e.ga == 1) inflight.push_back(fm.pop_front());
            if (e.gb == 1) inflight.push_back(fm.pop_front());
            if (fa) begin if (fm.size() < RRF_DEPTH) fm.push_back(ta); else m_err = 1; end
            if (fb) begin if (fm.size() < RRF_DEPTH) fm.push_back(tb); else m_err = 1; end
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("alloc_gnt_A", int'(bus.alloc_gnt_A), e.ga);
            chk("alloc_gnt_B", int'(bus.alloc_gnt_B), e.gb);
            chk("rrError_A", int'(bus.rrError_A), e.ea);
            chk("rrError_B", int'(bus.rrError_B), e.eb);
            chk("free_count", int'(bus.free_count), e.cnt);
            chk("err_overflow", int'(bus.err_overflow), e.err);
            if (e.ga == 1) chk("alloc_tag_A", int'(bus.alloc_tag_A), e.ta);
            if (e.gb == 1) chk("alloc_tag_B", int'(bus.alloc_tag_B), e.tb);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ta, tb, idx;
        bit fa, fb;
        rst_n = 1'b0;
        bus.map_req_A = 0; bus.map_req_B = 0; bus.free_en_A = 0; bus.free_en_B = 0;
        bus.free_tag_A = '0; bus.free_tag_B = '0; bus.flush = 0;
        repeat (2) @(posedge clk);
        mreset();
        m_err = 0;

        // Requests during reset are not granted.
        step(1, 1, 0, 0, 0, 0, 0, 1); #3;
        chk("rst_gnt_A", int'(bus.alloc_gnt_A), 0);
        chk("rst_free_count", int'(bus.free_count), 16);

        step(1, 1, 0, 0, 0, 0, 0, 0); #3;
        chk("first_tag_A", int'(bus.alloc_tag_A), 0);
        chk("first_tag_B", int'(bus.alloc_tag_B), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("count_after_pair", int'(bus.free_count), 14);

        // Drain to one free tag, then a dual request only gets A.
        repeat (6) step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0); #3;
        chk("last_gnt_A", int'(bus.alloc_gnt_A), 1);
        chk("last_gnt_B", int'(bus.alloc_gnt_B), 0);
        chk("last_rrError_B", int'(bus.rrError_B), 1);

        // Empty list: a same-cycle free is not bypassed to the request.
        drop_tag(5);
        step(1, 0, 1, 5, 0, 0, 0, 0); #3;
        chk("empty_count", int'(bus.free_count), 0);
        chk("empty_rrError_A", int'(bus.rrError_A), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("freed_gnt_A", int'(bus.alloc_gnt_A), 1);
        chk("freed_tag_A", int'(bus.alloc_tag_A), 5);

        // Two allocs and two frees in one cycle leave the count unchanged.
        drop_tag(3); drop_tag(7);
        step(0, 0, 1, 3, 1, 7, 0, 0);
        drop_tag(9); drop_tag(11);
        step(1, 1, 1, 9, 1, 11, 0, 0); #3;
        chk("balanced_gnt_B", int'(bus.alloc_gnt_B), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("balanced_count", int'(bus.free_count), 2);

        // Flush ignores requests and restores identity order.
        step(1, 0, 0, 0, 0, 0, 1, 0); #3;
        chk("flush_gnt_A", int'(bus.alloc_gnt_A), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("post_flush_count", int'(bus.free_count), 16);
        chk("post_flush_tag_A", int'(bus.alloc_tag_A), 0);

        // Random traffic; frees come only from outstanding tags.
        for (int n = 0; n < 1500; n++) begin
            fa = 0; fb = 0; ta = 0; tb = 0;
            if (inflight.size() > 0 && $urandom_range(0, 9) < 6) begin
                idx = $urandom_range(0, inflight.size() - 1);
                ta = inflight[idx]; inflight.delete(idx); fa = 1;
            end
            if (inflight.size() > 0 && $urandom_range(0, 9) < 6) begin
                idx = $urandom_range(0, inflight.size() - 1);
                tb = inflight[idx]; inflight.delete(idx); fb = 1;
            end
            step($urandom_range(0, 1), $urandom_range(0, 1), fa, ta, fb, tb,
                 ($urandom_range(0, 99) == 0), 0);
        end

        // Overflow: free into a full list; flag survives flush, cleared by reset.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("ovf_set", int'(bus.err_overflow), 1);
        chk("ovf_count_sat", int'(bus.free_count), 16);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0); #3;
        chk("ovf_after_flush", int'(bus.err_overflow), 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("ovf_cleared", int'(bus.err_overflow), 0);
        chk("reset_count", int'(bus.free_count), 16);

        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
